// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared arbiter definitions: state encoding, port count, select width, hold defaults
// Imported by every arbiter on the bus so encodings and sizes stay consistent.
package mem_port_arbiter_pkg;

  localparam int NUM_REQ      = 4;
  localparam int SEL_W        = 2;
  localparam int ARB_MAX_HOLD = 16;
  localparam int ARB_TIMER_W  = 5;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  function automatic logic [NUM_REQ-1:0] sel_to_onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick4.sv
// rtl/mem_port_arbiter_rr_pick4.sv - combinational round-robin pick over 4 requests
// Scans (ptr+1)%4 .. ptr and returns the first asserted request.
module mem_port_arbiter_rr_pick4
  import mem_port_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               valid,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] cand;

  // Walk from the lowest priority (ptr itself) up to the highest so the last hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one 32-bit port between 4 requesters
// Optional forced release after MAX_HOLD busy cycles under macro ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = ARB_MAX_HOLD,
  parameter int TIMER_W  = ARB_TIMER_W
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] Req,
  input  logic       Done,
  output logic [3:0] Grant,
  output logic [1:0] Sel,
  output logic       Busy,
  output logic       TimeoutErr
);

  arb_state_e         state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               pick_valid;
  logic [SEL_W-1:0]   pick_idx;
  logic               timeout;
  logic               release_now;
  logic               new_grant;

  // While busy the pointer already equals the owner, so one picker serves both cases.
  mem_port_arbiter_rr_pick4 u_pick (
    .req   (Req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign release_now = Done | ~Req[sel_q] | timeout;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    grant_d   = grant_q;
    new_grant = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d   = ARB_BUSY;
          new_grant = 1'b1;
        end
      end
      ARB_BUSY: begin
        if (release_now) begin
          if (pick_valid) begin
            new_grant = 1'b1;
          end else begin
            state_d = ARB_IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
    if (new_grant) begin
      ptr_d   = pick_idx;
      sel_d   = pick_idx;
      grant_d = sel_to_onehot(pick_idx);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ARB_IDLE;
      ptr_q   <= SEL_W'(NUM_REQ - 1);
      sel_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic               err_q, err_d;

  // Fires on the edge that completes the MAX_HOLD-th busy cycle.
  assign timeout = (state_q == ARB_BUSY) && (cnt_q == TIMER_W'(MAX_HOLD - 1));

  always_comb begin
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (new_grant || state_q == ARB_IDLE) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    if (state_q == ARB_BUSY && timeout && !Done && Req[sel_q]) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign TimeoutErr = err_q;
`else
  logic unused_cfg;
  assign unused_cfg = (MAX_HOLD < (1 << TIMER_W));
  assign timeout    = 1'b0;
  assign TimeoutErr = 1'b0;
`endif

  assign Grant = grant_q;
  assign Sel   = sel_q;
  assign Busy  = (state_q == ARB_BUSY);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] Req;
  logic       Done;
  logic [3:0] Grant;
  logic [1:0] Sel;
  logic       Busy;
  logic       TimeoutErr;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter dut (
    .CLK        (CLK),
    .RST        (RST),
    .Req        (Req),
    .Done       (Done),
    .Grant      (Grant),
    .Sel        (Sel),
    .Busy       (Busy),
    .TimeoutErr (TimeoutErr)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST  = 1'b1;
    Req  = 4'b1111;
    Done = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      n_checks++;
      if ({Grant, Sel, Busy, TimeoutErr} !== 8'b0) begin
        n_fail++;
        $display("FAIL reset_c%0d: grant=%b sel=%b busy=%b err=%b, need all zero", c, Grant, Sel, Busy, TimeoutErr);
      end
    end
    RST = 1'b0;
    Req = 4'b0000;
    step();
    n_checks++;
    if (Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b need 0", Busy);
    end
  endtask

  task automatic test_single();
    Req = 4'b0100;
    step();
    n_checks++;
    if (Grant !== 4'b0100 || Sel !== 2'b10 || Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: grant=%b sel=%b busy=%b need 0100/10/1", Grant, Sel, Busy);
    end
    step();
    n_checks++;
    if (Grant !== 4'b0100 || Sel !== 2'b10) begin
      n_fail++;
      $display("FAIL single_hold: grant=%b sel=%b need 0100/10", Grant, Sel);
    end
    Done = 1'b1;
    Req  = 4'b0000;
    step();
    n_checks++;
    if (Grant !== 4'b0000 || Busy !== 1'b0 || Sel !== 2'b10) begin
      n_fail++;
      $display("FAIL single_release: grant=%b busy=%b sel=%b need 0000/0/10", Grant, Busy, Sel);
    end
    step();
    n_checks++;
    if (Grant !== 4'b0000 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_idle: grant=%b busy=%b need 0000/0", Grant, Busy);
    end
    Done = 1'b0;
  endtask

  task automatic test_fairness();
    int exp_idx [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_g;
    RST = 1'b1;
    step();
    RST = 1'b0;
    Req = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << exp_idx[k];
      n_checks++;
      if (Grant !== exp_g || Sel !== 2'(exp_idx[k]) || Busy !== 1'b1) begin
        n_fail++;
        $display("FAIL fair_%0d: grant=%b sel=%b busy=%b need %b/%0d/1", k, Grant, Sel, Busy, exp_g, exp_idx[k]);
      end
      Done = 1'b0;
      step();
      n_checks++;
      if (Grant !== exp_g || Busy !== 1'b1) begin
        n_fail++;
        $display("FAIL fair_hold_%0d: grant=%b busy=%b need %b/1", k, Grant, Busy, exp_g);
      end
      Done = 1'b1;
      step();
      Done = 1'b0;
    end
    Req = 4'b0000;
    step();
    n_checks++;
    if (Busy !== 1'b0 || Grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL fair_drain: grant=%b busy=%b need 0000/0", Grant, Busy);
    end
  endtask

  task automatic test_abandon();
    Req = 4'b0010;
    step();
    n_checks++;
    if (Grant !== 4'b0010 || Sel !== 2'b01) begin
      n_fail++;
      $display("FAIL abandon_own: grant=%b sel=%b need 0010/01", Grant, Sel);
    end
    Req = 4'b1010;
    step();
    n_checks++;
    if (Grant !== 4'b0010) begin
      n_fail++;
      $display("FAIL abandon_wait: grant=%b need 0010", Grant);
    end
    Req = 4'b1000;
    step();
    n_checks++;
    if (Grant !== 4'b1000 || Sel !== 2'b11 || Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abandon_switch: grant=%b sel=%b busy=%b need 1000/11/1", Grant, Sel, Busy);
    end
    Req = 4'b0000;
    step();
  endtask

  task automatic test_timeout();
    RST = 1'b1;
    step();
    RST = 1'b0;
    Req = 4'b0011;
    step();
    n_checks++;
    if (Grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL to_first: grant=%b need 0001", Grant);
    end
    for (int c = 1; c < 16; c++) begin
      step();
      n_checks++;
      if (Grant !== 4'b0001 || TimeoutErr !== 1'b0) begin
        n_fail++;
        $display("FAIL to_hold_%0d: grant=%b err=%b need 0001/0", c, Grant, TimeoutErr);
      end
    end
    step();
`ifdef ARB_TIMEOUT_EN
    n_checks++;
    if (Grant !== 4'b0010 || Sel !== 2'b01 || TimeoutErr !== 1'b1) begin
      n_fail++;
      $display("FAIL to_fire: grant=%b sel=%b err=%b need 0010/01/1", Grant, Sel, TimeoutErr);
    end
    step();
    n_checks++;
    if (Grant !== 4'b0010 || TimeoutErr !== 1'b0) begin
      n_fail++;
      $display("FAIL to_pulse: grant=%b err=%b need 0010/0", Grant, TimeoutErr);
    end
`else
    n_checks++;
    if (Grant !== 4'b0001 || TimeoutErr !== 1'b0) begin
      n_fail++;
      $display("FAIL to_none: grant=%b err=%b need 0001/0", Grant, TimeoutErr);
    end
`endif
    Req = 4'b0000;
    step();
  endtask

  task automatic test_mid_reset();
    Req = 4'b0100;
    step();
    n_checks++;
    if (Grant !== 4'b0100) begin
      n_fail++;
      $display("FAIL mid_own: grant=%b need 0100", Grant);
    end
    RST = 1'b1;
    step();
    n_checks++;
    if (Grant !== 4'b0000 || Busy !== 1'b0 || Sel !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_reset: grant=%b busy=%b sel=%b need 0000/0/00", Grant, Busy, Sel);
    end
    RST = 1'b0;
    Req = 4'b0101;
    step();
    n_checks++;
    if (Grant !== 4'b0001 || Sel !== 2'b00 || Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_regrant: grant=%b sel=%b busy=%b need 0001/00/1", Grant, Sel, Busy);
    end
    Req = 4'b0000;
    step();
  endtask

  initial begin
    RST  = 1'b1;
    Req  = 4'b0000;
    Done = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_abandon();
    test_timeout();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
